// File: rtl/dcache_wb.sv
// rtl/dcache_wb.sv - direct-mapped, write-back, write-allocate data cache
// Hits complete in the request cycle; misses stall while the victim is written back and the block is filled.
module dcache_wb #(
  parameter int INDEX_W  = 3,
  parameter int OFFSET_W = 2,
  parameter int ADDR_W   = 30
) (
  input  logic                       clk,
  input  logic                       proc_reset,
  input  logic                       proc_read,
  input  logic                       proc_write,
  input  logic [ADDR_W-1:0]          proc_addr,
  input  logic [31:0]                proc_wdata,
  output logic                       proc_stall,
  output logic [31:0]                proc_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
  output logic [127:0]               mem_wdata,
  input  logic [127:0]               mem_rdata,
  input  logic                       mem_ready
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int NBLK  = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WB    = 2'd1,
    S_ALLOC = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [NBLK-1:0]   r_valid;
  logic [NBLK-1:0]   r_dirty;
  logic [TAG_W-1:0]  r_tag  [NBLK];
  logic [127:0]      r_data [NBLK];

  logic [INDEX_W-1:0]  w_idx;
  logic [TAG_W-1:0]    w_tag;
  logic [OFFSET_W-1:0] w_off;
  logic                w_req;
  logic                w_hit;
  logic                w_victim_dirty;

  assign w_idx          = proc_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign w_tag          = proc_addr[ADDR_W-1:OFFSET_W+INDEX_W];
  assign w_off          = proc_addr[OFFSET_W-1:0];
  assign w_req          = proc_read | proc_write;
  assign w_hit          = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] & r_dirty[w_idx];

  // Reset must drop the stall immediately even though the core may still be holding a request.
  assign proc_stall = ~proc_reset & w_req & ~w_hit;
  assign proc_rdata = w_hit ? r_data[w_idx][{w_off, 5'b0} +: 32] : 32'd0;
  assign mem_read   = r_mem_read;
  assign mem_write  = r_mem_write;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (r_state == S_ALLOC) begin
      mem_addr = proc_addr[ADDR_W-1:OFFSET_W];
    end else if (r_state == S_WB || r_valid[w_idx]) begin
      mem_addr  = {r_tag[w_idx], w_idx};
      mem_wdata = r_data[w_idx];
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state     <= S_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_valid     <= '0;
      r_dirty     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            if (w_victim_dirty) begin
              r_state     <= S_WB;
              r_mem_write <= 1'b1;
            end else begin
              r_state    <= S_ALLOC;
              r_mem_read <= 1'b1;
            end
          end else if (proc_write && w_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WB: begin
          if (mem_ready) begin
            r_state     <= S_ALLOC;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b1;
          end
        end
        S_ALLOC: begin
          if (mem_ready) begin
            r_state        <= S_IDLE;
            r_mem_read     <= 1'b0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits make their contents meaningful.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && proc_write && w_hit) begin
      r_data[w_idx][{w_off, 5'b0} +: 32] <= proc_wdata;
    end else if (r_state == S_ALLOC && mem_ready) begin
      r_data[w_idx] <= mem_rdata;
      r_tag[w_idx]  <= w_tag;
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// tb/tb_dcache_wb.sv - self-checking bench for dcache_wb
// Directed vector table, reset/idle corner sequences, then random traffic against a cache/memory model.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;

  dcache_wb dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lat = 4;
  bit spurious = 0;
  int wcnt = 0, nwb = 0, nrd = 0, excl_err = 0, act_cycles = 0;
  logic [27:0]  last_wb_addr, last_rd_addr;
  logic [127:0] last_wb_data;
  logic         obs_stall;
  logic [31:0]  obs_rdata;

  // Responder backing store and the independent model state.
  logic [127:0] bmem [logic [27:0]];
  logic [31:0]  mm_word [logic [29:0]];
  logic [31:0]  m_data [8][4];
  bit           mv [8];
  bit           md [8];
  logic [24:0]  mt [8];

  typedef struct {
    int           lat;
    bit           wr;
    logic [29:0]  addr;
    logic [31:0]  wdata;
    int           stall;
    int           nwb;
    int           nrd;
    logic [27:0]  rd_a;
    logic [27:0]  wb_a;
    logic [127:0] wb_d;
    logic [31:0]  rdata;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] bget(input logic [27:0] a);
    if (bmem.exists(a)) return bmem[a];
    return {a, 2'd3, 2'b00, a, 2'd2, 2'b00, a, 2'd1, 2'b00, a, 2'd0, 2'b00};
  endfunction

  // Memory before any write-back: the word at word-address A holds A*4.
  function automatic logic [31:0] mm_rd(input logic [29:0] a);
    if (mm_word.exists(a)) return mm_word[a];
    return {a, 2'b00};
  endfunction

  // One clock: sample at the falling edge, run the memory responder, advance past the rising edge.
  task automatic cyc();
    @(negedge clk);
    obs_stall = proc_stall;
    obs_rdata = proc_rdata;
    if (mem_read && mem_write) excl_err++;
    if (mem_read || mem_write) begin
      act_cycles++;
      if (wcnt >= lat) begin
        mem_ready = 1'b1;
        wcnt = 0;
        if (mem_write) begin
          nwb++;
          last_wb_addr = mem_addr;
          last_wb_data = mem_wdata;
          bmem[mem_addr] = mem_wdata;
        end else begin
          nrd++;
          last_rd_addr = mem_addr;
          mem_rdata = bget(mem_addr);
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
      if (spurious) begin
        mem_ready = 1'b1;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  task automatic do_req(input bit wr, input logic [29:0] a, input logic [31:0] d,
                        output int st, output logic [31:0] rd, output int dwb, output int drd);
    int wb0, rd0;
    bit done;
    wb0 = nwb; rd0 = nrd; st = 0; done = 0;
    proc_read = !wr; proc_write = wr; proc_addr = a; proc_wdata = d;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (!obs_stall) begin done = 1; break; end
      st++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL req_timeout actual=stalled expected=done addr=%0h", a);
    end
    rd = obs_rdata; dwb = nwb - wb0; drd = nrd - rd0;
    proc_read = 0; proc_write = 0;
  endtask

  task automatic model_req(input bit wr, input logic [29:0] a, input logic [31:0] d,
                           output int e_st, output bit e_wb, output logic [27:0] e_wba,
                           output logic [127:0] e_wbd, output bit e_rd, output logic [31:0] e_rdata);
    int idx, w;
    logic [24:0] tg;
    bit hit;
    idx = int'(a[4:2]); w = int'(a[1:0]); tg = a[29:5];
    hit = mv[idx] && mt[idx] == tg;
    e_wb = !hit && mv[idx] && md[idx];
    e_rd = !hit;
    e_wba = {mt[idx], 3'(idx)};
    e_wbd = {m_data[idx][3], m_data[idx][2], m_data[idx][1], m_data[idx][0]};
    if (e_wb)
      for (int k = 0; k < 4; k++) mm_word[{mt[idx], 3'(idx), 2'(k)}] = m_data[idx][k];
    if (!hit) begin
      for (int k = 0; k < 4; k++) m_data[idx][k] = mm_rd({tg, 3'(idx), 2'(k)});
      mv[idx] = 1; mt[idx] = tg; md[idx] = 0;
    end
    e_st = hit ? 0 : (e_wb ? 2 * lat + 3 : lat + 2);
    e_rdata = m_data[idx][w];
    if (wr) begin m_data[idx][w] = d; md[idx] = 1; end
  endtask

  task automatic mreq(input bit wr, input logic [29:0] a, input logic [31:0] d);
    int e_st, st, dwb, drd;
    bit e_wb, e_rd;
    logic [27:0] e_wba;
    logic [127:0] e_wbd;
    logic [31:0] e_rdata, rd;
    model_req(wr, a, d, e_st, e_wb, e_wba, e_wbd, e_rd, e_rdata);
    do_req(wr, a, d, st, rd, dwb, drd);
    chk("stall_cycles", st, e_st);
    chk("wb_count", dwb, e_wb);
    chk("fill_count", drd, e_rd);
    if (e_wb) begin
      chk("wb_addr", last_wb_addr, e_wba);
      chk("wb_data", last_wb_data, e_wbd);
    end
    if (e_rd) chk("fill_addr", last_rd_addr, a[29:2]);
    if (!wr) chk("rdata", rd, e_rdata);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mv[i] = 0; md[i] = 0; end
  endtask

  initial begin
    int st, dwb, drd, e_st, a0;
    bit e_wb, e_rd;
    logic [27:0] e_wba;
    logic [127:0] e_wbd;
    logic [31:0] rd, e_rdata;

    tv[0] = '{4, 0, 30'h10, 32'h0,        6,  0, 1, 28'h4,  28'h0,  128'h0, 32'h40};
    tv[1] = '{4, 1, 30'h11, 32'hDEADBEEF, 0,  0, 0, 28'h0,  28'h0,  128'h0, 32'h0};
    tv[2] = '{4, 0, 30'h11, 32'h0,        0,  0, 0, 28'h0,  28'h0,  128'h0, 32'hDEADBEEF};
    tv[3] = '{4, 0, 30'h30, 32'h0,        11, 1, 1, 28'hC,  28'h4,
              {32'h4C, 32'h48, 32'hDEADBEEF, 32'h40}, 32'hC0};
    tv[4] = '{4, 0, 30'h11, 32'h0,        6,  0, 1, 28'h4,  28'h0,  128'h0, 32'hDEADBEEF};
    tv[5] = '{4, 0, 30'h31, 32'h0,        6,  0, 1, 28'hC,  28'h0,  128'h0, 32'hC4};
    tv[6] = '{4, 0, 30'h12, 32'h0,        6,  0, 1, 28'h4,  28'h0,  128'h0, 32'h48};
    tv[7] = '{0, 0, 30'h50, 32'h0,        2,  0, 1, 28'h14, 28'h0,  128'h0, 32'h140};
    tv[8] = '{0, 1, 30'h51, 32'hCAFEF00D, 0,  0, 0, 28'h0,  28'h0,  128'h0, 32'h0};
    tv[9] = '{1, 0, 30'h10, 32'h0,        5,  1, 1, 28'h4,  28'h14,
              {32'h14C, 32'h148, 32'hCAFEF00D, 32'h140}, 32'h40};

    proc_reset = 1; proc_read = 0; proc_write = 0; proc_addr = 0; proc_wdata = 0;
    mem_rdata = 0; mem_ready = 0;
    model_reset();
    #2;
    chk("rst_stall", proc_stall, 0);
    chk("rst_rdata", proc_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    proc_read = 1; proc_addr = 30'h10;
    #1;
    chk("rst_stall_with_req", proc_stall, 0);
    proc_read = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    proc_reset = 0;
    #1;
    chk("idle_no_stall", proc_stall, 0);

    for (int i = 0; i < 10; i++) begin
      lat = tv[i].lat;
      model_req(tv[i].wr, tv[i].addr, tv[i].wdata, e_st, e_wb, e_wba, e_wbd, e_rd, e_rdata);
      do_req(tv[i].wr, tv[i].addr, tv[i].wdata, st, rd, dwb, drd);
      chk($sformatf("v%0d_stall", i), st, tv[i].stall);
      chk($sformatf("v%0d_wb", i), dwb, tv[i].nwb);
      chk($sformatf("v%0d_fill", i), drd, tv[i].nrd);
      if (tv[i].nrd != 0) chk($sformatf("v%0d_fill_addr", i), last_rd_addr, tv[i].rd_a);
      if (tv[i].nwb != 0) begin
        chk($sformatf("v%0d_wb_addr", i), last_wb_addr, tv[i].wb_a);
        chk($sformatf("v%0d_wb_data", i), last_wb_data, tv[i].wb_d);
      end
      if (!tv[i].wr) chk($sformatf("v%0d_rdata", i), rd, tv[i].rdata);
    end

    // Reset while a write-back is in flight: the dirty word is lost and the line is invalid.
    lat = 4;
    mreq(1, 30'h11, 32'h12345678);
    proc_read = 1; proc_addr = 30'h31;
    cyc();
    chk("wb_started", mem_write, 1);
    chk("wb_started_addr", mem_addr, 28'h4);
    proc_reset = 1;
    #1;
    chk("async_rst_mem_write", mem_write, 0);
    chk("async_rst_mem_read", mem_read, 0);
    chk("async_rst_stall", proc_stall, 0);
    model_reset();
    cyc();
    chk("stall_in_reset", obs_stall, 0);
    cyc();
    proc_read = 0; proc_reset = 0;
    mreq(0, 30'h11, 0);
    mreq(0, 30'h31, 0);

    // Fill every index, then back-to-back hits with mem_ready pulsing in idle.
    lat = 2;
    for (int i = 0; i < 8; i++) mreq(0, {25'd3, 3'(i), 2'd0}, 0);
    spurious = 1;
    a0 = act_cycles;
    for (int i = 0; i < 16; i++) mreq(i[0], {25'd3, 3'(i), 2'($urandom)}, $urandom);
    chk("hits_no_mem_activity", act_cycles - a0, 0);
    spurious = 0;

    for (int n = 0; n < 200; n++) begin
      lat = $urandom_range(0, 5);
      mreq(1'($urandom), {23'd0, 2'($urandom), 3'($urandom), 2'($urandom)}, $urandom);
    end

    chk("mem_rw_exclusive", excl_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
